// File: rtl/css_pkg.sv
// css_pkg: shared constants and the per-stage pipeline register layout for
// the 16-bit carry-select subtractor. With CSS_FLAGS_EN defined the stage
// register also carries the zero/neg/ovf status flags.
package css_pkg;

   localparam int CSS_WIDTH   = 16;
   localparam int CSS_SLICE_W = 4;
   localparam int CSS_N_SLICE = 4;

   // One pipeline stage: valid, carry into the next slice, the difference
   // bits completed so far, and the operands (a and ~b) whose upper bits
   // are still to be consumed by later slices.
   typedef struct packed {
      logic                 v;
      logic                 carry;
      logic [CSS_WIDTH-1:0] diff;
      logic [CSS_WIDTH-1:0] a;
      logic [CSS_WIDTH-1:0] nb;
`ifdef CSS_FLAGS_EN
      logic                 zero;
      logic                 neg;
      logic                 ovf;
`endif
   } css_stage_t;

endpackage

// File: rtl/sub_select_slice_4bit.sv
// sub_select_slice_4bit: combinational 4-bit carry-select slice. Adds a and
// the inverted subtrahend for both possible carry-in values and picks one
// with the carry registered by the previous pipeline stage.
module sub_select_slice_4bit
   import css_pkg::*;
(
   input  logic [CSS_SLICE_W-1:0] a,
   input  logic [CSS_SLICE_W-1:0] nb,
   input  logic                   sel,
   output logic [CSS_SLICE_W-1:0] diff,
   output logic                   cout
);

   logic [CSS_SLICE_W:0] sum0;
   logic [CSS_SLICE_W:0] sum1;

   // Evaluate both carry-in hypotheses, then let the late-arriving carry pick.
   always_comb begin
      sum0         = {1'b0, a} + {1'b0, nb};
      sum1         = {1'b0, a} + {1'b0, nb} + {{CSS_SLICE_W{1'b0}}, 1'b1};
      {cout, diff} = sel ? sum1 : sum0;
   end

endmodule

// File: rtl/carry_select_subtractor_16bit_pipe.sv
// carry_select_subtractor_16bit_pipe: streaming a - b - bin with one 4-bit
// slice per pipeline stage, valid/ready handshake with a global stall.
// Optional feature macro: CSS_FLAGS_EN adds registered zero/neg/ovf outputs.
module carry_select_subtractor_16bit_pipe
   import css_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CSS_WIDTH-1:0] a,
   input  logic [CSS_WIDTH-1:0] b,
   input  logic                 bin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CSS_WIDTH-1:0] diff,
   output logic                 bout
`ifdef CSS_FLAGS_EN
   ,
   output logic                 zero,
   output logic                 neg,
   output logic                 ovf
`endif
);

   localparam int LAST = CSS_N_SLICE - 1;

   css_stage_t             pipe_q [CSS_N_SLICE];
   css_stage_t             pipe_d [CSS_N_SLICE];
   logic [CSS_SLICE_W-1:0] slice_diff [CSS_N_SLICE];
   logic                   slice_cout [CSS_N_SLICE];
   logic                   stall;
   logic                   accept;

   // Slice 0 ripples straight from the inputs with carry-in ~bin; the later
   // slices select on the carry held in the preceding stage register.
   generate
      for (genvar gi = 0; gi < CSS_N_SLICE; gi++) begin : g_slice
         if (gi == 0) begin : g_first
            assign {slice_cout[gi], slice_diff[gi]} =
               {1'b0, a[CSS_SLICE_W-1:0]} + {1'b0, ~b[CSS_SLICE_W-1:0]} +
               {{CSS_SLICE_W{1'b0}}, ~bin};
         end else begin : g_sel
            sub_select_slice_4bit u_slice (
               .a    (pipe_q[gi-1].a[gi*CSS_SLICE_W +: CSS_SLICE_W]),
               .nb   (pipe_q[gi-1].nb[gi*CSS_SLICE_W +: CSS_SLICE_W]),
               .sel  (pipe_q[gi-1].carry),
               .diff (slice_diff[gi]),
               .cout (slice_cout[gi])
            );
         end
      end
   endgenerate

   // Handshake plus next-state of every stage register.
   always_comb begin
      stall  = pipe_q[LAST].v && !out_ready;
      accept = in_valid && !stall;

      pipe_d[0]                        = '0;
      pipe_d[0].v                      = accept;
      pipe_d[0].carry                  = slice_cout[0];
      pipe_d[0].diff[CSS_SLICE_W-1:0]  = slice_diff[0];
      pipe_d[0].a                      = a;
      pipe_d[0].nb                     = ~b;

      for (int k = 1; k < CSS_N_SLICE; k++) begin
         pipe_d[k]                                 = pipe_q[k-1];
         pipe_d[k].carry                           = slice_cout[k];
         pipe_d[k].diff[k*CSS_SLICE_W +: CSS_SLICE_W] = slice_diff[k];
      end

`ifdef CSS_FLAGS_EN
      // Flags are formed from the completed difference as it enters the last
      // register; b[15] is recovered by re-inverting the carried ~b.
      pipe_d[LAST].zero = (pipe_d[LAST].diff == '0);
      pipe_d[LAST].neg  = pipe_d[LAST].diff[CSS_WIDTH-1];
      pipe_d[LAST].ovf  = (pipe_q[LAST-1].a[CSS_WIDTH-1] != ~pipe_q[LAST-1].nb[CSS_WIDTH-1]) &&
                          (pipe_d[LAST].diff[CSS_WIDTH-1] != pipe_q[LAST-1].a[CSS_WIDTH-1]);
`endif
   end

   // Stage registers: cleared on reset (carry=1 means "no borrow"), frozen
   // as a whole while the consumer stalls, otherwise all advance together.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CSS_N_SLICE; i++) begin
            pipe_q[i]       <= '0;
            pipe_q[i].carry <= 1'b1;
         end
      end else if (!stall) begin
         for (int i = 0; i < CSS_N_SLICE; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign in_ready  = !stall;
   assign out_valid = pipe_q[LAST].v;
   assign diff      = pipe_q[LAST].diff;
   assign bout      = ~pipe_q[LAST].carry;
`ifdef CSS_FLAGS_EN
   assign zero      = pipe_q[LAST].zero;
   assign neg       = pipe_q[LAST].neg;
   assign ovf       = pipe_q[LAST].ovf;
`endif

endmodule

// File: tb/tb_carry_select_subtractor_16bit_pipe.sv
// Directed bench for carry_select_subtractor_16bit_pipe: reset state, single
// operations with latency check, backpressure, and reset mid-flight.
module tb_carry_select_subtractor_16bit_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
`ifdef CSS_FLAGS_EN
   logic        zero;
   logic        neg;
   logic        ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bo;
      logic        z;
      logic        n;
      logic        o;
   } vec_t;

   vec_t dir_v [8];
   vec_t ops_v [8];

   always #5 clk = ~clk;

   carry_select_subtractor_16bit_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef CSS_FLAGS_EN
      ,
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
      end
   endtask

   // One isolated operation: presented, accepted on the next edge, result
   // expected on the fourth edge after presentation and not before.
   task automatic run_single(input string tag, input vec_t v);
      a        = v.a;
      b        = v.b;
      bin      = v.bin;
      in_valid = 1'b1;
      check1($sformatf("%s_inrdy", tag), in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      step();
      check1($sformatf("%s_early", tag), out_valid, 1'b0);
      step();
      check1($sformatf("%s_ovalid", tag), out_valid, 1'b1);
      check16($sformatf("%s_diff", tag), diff, v.d);
      check1($sformatf("%s_bout", tag), bout, v.bo);
`ifdef CSS_FLAGS_EN
      check1($sformatf("%s_zero", tag), zero, v.z);
      check1($sformatf("%s_neg", tag), neg, v.n);
      check1($sformatf("%s_ovf", tag), ovf, v.o);
`endif
      $display("op %s: a=%04h b=%04h bin=%0b -> diff=%04h bout=%0b", tag, v.a, v.b, v.bin, diff, bout);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int rcv;
      int stall_left;
      bit stall_done;

      //            a         b         bin   diff      bout  z     n     o
      dir_v[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
      dir_v[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      dir_v[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
      dir_v[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
      dir_v[4] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      dir_v[5] = '{16'h1235, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      dir_v[6] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
      dir_v[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};

      ops_v[0] = '{16'hA5A5, 16'h1234, 1'b0, 16'h9371, 1'b0, 1'b0, 1'b1, 1'b0};
      ops_v[1] = '{16'h0100, 16'h0200, 1'b0, 16'hFF00, 1'b1, 1'b0, 1'b1, 1'b0};
      ops_v[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      ops_v[3] = '{16'h4321, 16'h0321, 1'b1, 16'h3FFF, 1'b0, 1'b0, 1'b0, 1'b0};
      ops_v[4] = '{16'h0F0F, 16'h00F0, 1'b0, 16'h0E1F, 1'b0, 1'b0, 1'b0, 1'b0};
      ops_v[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      ops_v[6] = '{16'h1000, 16'h2000, 1'b1, 16'hEFFF, 1'b1, 1'b0, 1'b1, 1'b0};
      ops_v[7] = '{16'hDEAD, 16'hBEEF, 1'b0, 16'h1FBE, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset, with in_valid asserted throughout (must be ignored).
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 16'hFFFF;
      b         = 16'h0000;
      bin       = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check1("rst_ovalid", out_valid, 1'b0);
      check1("rst_inrdy", in_ready, 1'b1);
      check16("rst_diff", diff, 16'h0000);
      check1("rst_bout", bout, 1'b0);
`ifdef CSS_FLAGS_EN
      check1("rst_zero", zero, 1'b0);
      check1("rst_neg", neg, 1'b0);
      check1("rst_ovf", ovf, 1'b0);
`endif
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check1("rst_ignored_in", out_valid, 1'b0);
      end
      $display("reset: out_valid=%0b in_ready=%0b diff=%04h", out_valid, in_ready, diff);

      // Directed single operations.
      for (int i = 0; i < 8; i++) begin
         run_single($sformatf("dir%0d", i), dir_v[i]);
      end

      // out_ready low on an empty pipe must not stall the fill.
      out_ready = 1'b0;
      a         = dir_v[2].a;
      b         = dir_v[2].b;
      bin       = dir_v[2].bin;
      in_valid  = 1'b1;
      #1;
      check1("nrdy_inrdy", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      check1("nrdy_ovalid", out_valid, 1'b1);
      check1("nrdy_stall_inrdy", in_ready, 1'b0);
      check16("nrdy_diff", diff, dir_v[2].d);
      step();
      check1("nrdy_hold_ovalid", out_valid, 1'b1);
      check16("nrdy_hold_diff", diff, dir_v[2].d);
      out_ready = 1'b1;
      #1;
      check1("nrdy_release_inrdy", in_ready, 1'b1);
      step();
      check1("nrdy_drained", out_valid, 1'b0);
      $display("empty-pipe out_ready low: result %04h delivered after release", dir_v[2].d);

      // Backpressure: 8 back-to-back ops, 3-cycle stall once the pipe is full.
      sent       = 0;
      rcv        = 0;
      stall_left = 0;
      stall_done = 1'b0;
      for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
         if (out_valid && !stall_done && stall_left == 0) stall_left = 3;
         out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
         if (sent < 8) begin
            a        = ops_v[sent].a;
            b        = ops_v[sent].b;
            bin      = ops_v[sent].bin;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stall_left > 0) begin
            check1("bp_stall_inrdy", in_ready, 1'b0);
            check1("bp_stall_ovalid", out_valid, 1'b1);
            check16("bp_stall_diff", diff, ops_v[rcv].d);
            check1("bp_stall_bout", bout, ops_v[rcv].bo);
         end else if (stall_done) begin
            check1("bp_nogap", out_valid, 1'b1);
         end
         if (out_valid && out_ready) begin
            check16($sformatf("bp_diff%0d", rcv), diff, ops_v[rcv].d);
            check1($sformatf("bp_bout%0d", rcv), bout, ops_v[rcv].bo);
`ifdef CSS_FLAGS_EN
            check1($sformatf("bp_zero%0d", rcv), zero, ops_v[rcv].z);
            check1($sformatf("bp_neg%0d", rcv), neg, ops_v[rcv].n);
`endif
            $display("bp result %0d: diff=%04h bout=%0b", rcv, diff, bout);
            rcv++;
         end
         if (in_valid && in_ready) sent++;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall_done = 1'b1;
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check16("bp_count", 16'(rcv), 16'd8);
      check1("bp_stalled", stall_done, 1'b1);

      // Reset with three operations in flight.
      step();
      for (int i = 0; i < 3; i++) begin
         a        = ops_v[i].a;
         b        = ops_v[i].b;
         bin      = ops_v[i].bin;
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      check1("rmf_ovalid", out_valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         check1("rmf_flushed", out_valid, 1'b0);
      end
      $display("reset mid-flight: pipe flushed, out_valid=%0b", out_valid);
      run_single("rmf_new", dir_v[3]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
